// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_sequencer : eight-phase fetch/execute control sequencer, sticky halt
// Revision      : 1.0
// ============================================================================
module cpu_sequencer #(
  parameter int OPCODE_WIDTH = 3,
  parameter int PHASE_WIDTH  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  output logic                    sel,
  output logic                    rd,
  output logic                    wr,
  output logic                    ld_ir,
  output logic                    inc_pc,
  output logic                    ld_pc,
  output logic                    ld_ac,
  output logic                    data_e,
  output logic                    halt,
  output logic [PHASE_WIDTH-1:0]  phase
);

  typedef enum logic [PHASE_WIDTH-1:0] {
    INST_ADDR,
    INST_FETCH,
    INST_LOAD,
    IDLE,
    OP_ADDR,
    OP_FETCH,
    ALU_OP,
    STORE
  } phase_e;

  localparam logic [OPCODE_WIDTH-1:0] c_hlt = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] c_skz = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] c_add = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] c_and = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] c_xor = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] c_lda = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] c_sto = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] c_jmp = OPCODE_WIDTH'(7);

  phase_e phase_q, phase_d;
  logic   halt_q, halt_d;
  logic   w_aluop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= INST_ADDR;
      halt_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    halt_d  = halt_q;
    sel     = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    ld_ir   = 1'b0;
    inc_pc  = 1'b0;
    ld_pc   = 1'b0;
    ld_ac   = 1'b0;
    data_e  = 1'b0;
    w_aluop = (opcode == c_add) || (opcode == c_and) ||
              (opcode == c_xor) || (opcode == c_lda);

    // HLT is recognised once the opcode is stable in the IR, skipping the operand phases
    if (en && !halt_q) begin
      if (phase_q == OP_ADDR && opcode == c_hlt) begin
        halt_d  = 1'b1;
        phase_d = OP_FETCH;
      end else begin
        phase_d = phase_e'(phase_q + PHASE_WIDTH'(1));
      end
    end

    if (halt_q) begin
      sel = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD,
        IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        OP_ADDR:    inc_pc = 1'b1;
        OP_FETCH:   rd = w_aluop;
        ALU_OP: begin
          rd     = w_aluop;
          inc_pc = (opcode == c_skz) && zero;
          ld_pc  = (opcode == c_jmp);
          data_e = (opcode == c_sto);
        end
        STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = (opcode == c_jmp);
          wr     = (opcode == c_sto);
          data_e = (opcode == c_sto);
        end
        default: sel = 1'b1;
      endcase
    end
  end

  assign halt  = halt_q;
  assign phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_sequencer : randomized self-checking bench with a phase-table model
// Revision         : 1.0
// ============================================================================
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, zero;
  logic [2:0] opcode;
  logic       sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt;
  logic [2:0] phase;
  logic [11:0] dut_vec;
  logic [11:0] e;

  int checks = 0;
  int errors = 0;
  int m_phase = 0;
  bit m_halt = 1'b0;

  cpu_sequencer #(.OPCODE_WIDTH(3), .PHASE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .inc_pc(inc_pc),
    .ld_pc(ld_pc), .ld_ac(ld_ac), .data_e(data_e), .halt(halt), .phase(phase)
  );

  always #5 clk = ~clk;

  assign dut_vec = {sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, data_e, halt, phase};

  // Expected outputs straight from the phase table: {sel,rd,wr,ld_ir,inc_pc,ld_pc,ld_ac,data_e,halt,phase}
  function automatic logic [11:0] exp_vec(int p, bit h, logic [2:0] op, logic z);
    bit alu, s, r, w, ir, ip, lp, la, de;
    alu = (op >= 3'd2) && (op <= 3'd5);
    if (h) return {1'b1, 7'b0, 1'b1, 3'(p)};
    s  = (p < 4);
    r  = (p >= 1 && p <= 3) || (p >= 5 && alu);
    ir = (p == 2 || p == 3);
    ip = (p == 4) || (p == 6 && op == 3'd1 && z);
    lp = (p == 6 || p == 7) && op == 3'd7;
    de = (p == 6 || p == 7) && op == 3'd6;
    w  = (p == 7) && op == 3'd6;
    la = (p == 7) && alu;
    return {s, r, w, ir, ip, lp, la, de, 1'b0, 3'(p)};
  endfunction

  task automatic set_in(input bit e_i, input logic [2:0] op, input logic z);
    en = e_i; opcode = op; zero = z;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst && !m_halt && en) begin
      if (m_phase == 4 && opcode == 3'd0) begin
        m_halt = 1'b1;
        m_phase = 5;
      end else begin
        m_phase = (m_phase + 1) % 8;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((rd && wr) || (ld_pc && inc_pc) || (wr && !data_e)) begin
        errors++;
        $display("FAIL exclusion: rd=%b wr=%b ld_pc=%b inc_pc=%b data_e=%b, required no rd&wr, no ld_pc&inc_pc, wr->data_e",
                 rd, wr, ld_pc, inc_pc, data_e);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    m_phase = 0; m_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'($urandom), 3'($urandom), 1'($urandom));
      e = exp_vec(0, 1'b0, opcode, zero);
      checks++;
      if (dut_vec !== e || dut_vec !== 12'b1000_0000_0000) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b want %b", i, dut_vec, 12'b1000_0000_0000);
      end
      if (i < 2) advance();
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 9; k++) begin
      set_in(1'b1, 3'($urandom_range(7, 1)), 1'($urandom));
      e = exp_vec(m_phase, m_halt, opcode, zero);
      checks++;
      if (dut_vec !== e || phase !== 3'(k % 8) || sel !== (k % 8 < 4)) begin
        errors++;
        $display("FAIL wrap step%0d: got %b want %b", k, dut_vec, e);
      end
      advance();
    end
    for (int k = 0; k < 7; k++) begin
      set_in(1'b1, 3'd5, 1'b0);
      advance();
    end
  endtask

  task automatic run_instr(input string name, input logic [2:0] op, input logic z);
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, op, z);
      e = exp_vec(m_phase, m_halt, opcode, zero);
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL %s phase%0d: got %b want %b", name, m_phase, dut_vec, e);
      end
      advance();
    end
  endtask

  task automatic test_lda();
    run_instr("lda", 3'd5, 1'($urandom));
  endtask

  task automatic test_sto();
    run_instr("sto", 3'd6, 1'($urandom));
  endtask

  task automatic test_skz();
    run_instr("skz_z1", 3'd1, 1'b1);
    run_instr("skz_z0", 3'd1, 1'b0);
    run_instr("jmp", 3'd7, 1'($urandom));
  endtask

  task automatic test_hlt();
    run_instr("hlt_pre", 3'd0, 1'b0);
    checks++;
    if (halt !== 1'b1 || phase !== 3'd5) begin
      errors++;
      $display("FAIL hlt_entry: got halt=%b phase=%0d want halt=1 phase=5", halt, phase);
    end
    for (int k = 0; k < 20; k++) begin
      set_in(1'($urandom), 3'($urandom), 1'($urandom));
      e = exp_vec(m_phase, m_halt, opcode, zero);
      checks++;
      if (dut_vec !== e || dut_vec !== 12'b1000_0000_1101) begin
        errors++;
        $display("FAIL halted cyc%0d: got %b want %b", k, dut_vec, 12'b1000_0000_1101);
      end
      advance();
    end
    rst = 1'b1;
    m_phase = 0; m_halt = 1'b0;
    #1;
    checks++;
    if (halt !== 1'b0 || phase !== 3'd0) begin
      errors++;
      $display("FAIL hlt_reset: got halt=%b phase=%0d want halt=0 phase=0", halt, phase);
    end
    advance();
    rst = 1'b0;
  endtask

  task automatic test_stall();
    for (int k = 0; k < 2; k++) begin set_in(1'b1, 3'd5, 1'b0); advance(); end
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, 3'd5, 1'b0);
      e = exp_vec(m_phase, m_halt, opcode, zero);
      checks++;
      if (dut_vec !== e || phase !== 3'd2 || rd !== 1'b1 || ld_ir !== 1'b1) begin
        errors++;
        $display("FAIL stall cyc%0d: got %b want %b", k, dut_vec, e);
      end
      advance();
    end
    for (int k = 0; k < 6; k++) begin set_in(1'b1, 3'd5, 1'b0); advance(); end
  endtask

  task automatic test_abort();
    for (int k = 0; k < 6; k++) begin set_in(1'b1, 3'd7, 1'b0); advance(); end
    checks++;
    if (ld_pc !== 1'b1 || phase !== 3'd6) begin
      errors++;
      $display("FAIL abort_pre: got ld_pc=%b phase=%0d want ld_pc=1 phase=6", ld_pc, phase);
    end
    #2;
    rst = 1'b1;
    m_phase = 0; m_halt = 1'b0;
    #1;
    e = exp_vec(0, 1'b0, opcode, zero);
    checks++;
    if (ld_pc !== 1'b0 || phase !== 3'd0 || dut_vec !== e) begin
      errors++;
      $display("FAIL abort: got %b want %b", dut_vec, e);
    end
    advance();
    rst = 1'b0;
  endtask

  task automatic test_random();
    int halted_for;
    halted_for = 0;
    for (int k = 0; k < 400; k++) begin
      set_in(($urandom % 4) != 0, 3'($urandom), 1'($urandom));
      e = exp_vec(m_phase, m_halt, opcode, zero);
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL random cyc%0d: got %b want %b", k, dut_vec, e);
      end
      halted_for = m_halt ? halted_for + 1 : 0;
      if (halted_for > 4 || ($urandom % 97) == 0) begin
        rst = 1'b1;
        m_phase = 0; m_halt = 1'b0;
        halted_for = 0;
        #1;
        e = exp_vec(0, 1'b0, opcode, zero);
        checks++;
        if (dut_vec !== e) begin
          errors++;
          $display("FAIL random_rst cyc%0d: got %b want %b", k, dut_vec, e);
        end
        advance();
        rst = 1'b0;
      end else begin
        advance();
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; opcode = 3'd0; zero = 1'b0;
    test_reset();
    test_wrap();
    test_lda();
    test_sto();
    test_skz();
    test_hlt();
    test_stall();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
